sparc_ifu_thrsched: RTL
=======================

# sparc_ifu_thrsched

Per-thread scheduling state machine for the four-thread IFU; consumes the unified `completion` vector and wait masks produced by thread completion logic and decides which thread owns the fetch/switch slot. Holds one state machine per thread plus a round-robin pointer, and presents a registered one-hot running-thread vector to fetch control. Sits directly downstream of thread completion and upstream of fetch-thread select muxing.

## Interface
Parameters:
- NTHR, 4, thread count (only 4 is supported; vectors are one bit per thread)

Ports:
- clk  in  1  core clock
- arst_l  in  1  asynchronous active-low reset
- thr_start  in  4  resume/power-on request per thread (HALT -> RDY)
- thr_stop  in  4  park request per thread (any -> HALT)
- completion  in  4  wake-up per thread from completion logic
- spec_cmpl  in  4  predicted completion (used only with macro)
- spec_fail  in  4  predicted completion cancelled (used only with macro)
- switch_s  in  1  running thread switches out and waits
- yield_s  in  1  running thread switches out without waiting
- stall_s  in  1  hold current selection; no RUN change
- thr_run  out  4  one-hot running thread, registered; 0 = none
- thr_rdy  out  4  threads in RDY
- thr_wait  out  4  threads in WAIT or SPEC
- thr_halt  out  4  threads in HALT
- all_idle  out  1  no thread RUN, RDY or SPEC

## Operation
- Per-thread states: HALT=0, RDY=1, RUN=2, WAIT=3, SPEC=4 (3-bit); at most one thread in RUN.
- Transition priority per thread, highest first: thr_stop -> HALT; then:
  - HALT: thr_start -> RDY; else stay.
  - RUN: switch_s -> WAIT, unless completion same cycle -> RDY; yield_s -> RDY; both set -> switch_s rule.
  - WAIT: completion -> RDY; else spec_cmpl -> SPEC (macro only).
  - SPEC: completion -> RDY; spec_fail -> WAIT; selected -> RUN.
  - RDY: selected -> RUN.
- Selection happens when no thread is RUN, or the RUN thread leaves RUN this cycle, and stall_s=0.
- Search order starts at rr_ptr+1 mod 4, wraps; first RDY wins; if none RDY, first SPEC wins (macro); if none, thr_run becomes 0.
- rr_ptr (2 bits) updates to selected index on every selection; unchanged otherwise.
- thr_start on a non-HALT thread ignored; completion in HALT/RDY/RUN (except switch cycle) ignored.
- stall_s=1: no selection, RUN thread stays RUN unless thr_stop; switch_s/yield_s still honoured (slot empties, thr_run=0 next cycle).

## Timing
- Reset (async assert, sync-released sampling): all threads HALT, rr_ptr=3, thr_run=0, thr_rdy=0, thr_wait=0, thr_halt=4'hF, all_idle=1.
- State and thr_run registered; status outputs decode current state (combinational from flops).
- Switch at cycle N with a RDY thread available -> new thread in thr_run at N+1 (zero bubble).
- thr_start at N -> RDY at N+1 -> earliest RUN at N+2.
- completion at N for WAIT thread -> RDY at N+1.
- thr_stop on RUN thread at N -> thr_run=0 at N+1; reselection at N+1 evaluated, RUN at N+2.

## Configuration
- SPARC_IFU_THRSCHED_SPEC_EN defined: SPEC state active; spec_cmpl/spec_fail honoured; SPEC threads selectable below RDY; selected SPEC thread in RUN that gets spec_fail stays RUN (fetch control squashes).
- Undefined: spec_cmpl/spec_fail ignored, SPEC unreachable, thr_wait = WAIT only.

## Structure
- Shared package: state encodings (HALT..SPEC), NTHR, rr_ptr width.
- One sub-module `sparc_ifu_thrfsm` instantiated 4x (per-thread state machine, takes sel and switch/yield gated by own run bit); round-robin picker and rr_ptr in top.

## Test plan
- Reset, thr_start=4'b0101 at cycle 1 -> thr_run=4'b0001 at cycle 3, thr_rdy=4'b0100.
- T0 running, switch_s at N, T2 RDY -> thr_run=4'b0100 at N+1, thr_wait=4'b0001; completion[0] at N+3 -> thr_rdy=4'b0001 at N+4.
- All four RDY, repeated yield_s -> thr_run sequence 0001,0010,0100,1000,0001 (wrap).
- switch_s with completion[i] same cycle for running Ti, no others RDY -> Ti RDY then RUN again, thr_wait stays 0.
- stall_s=1 with thr_run=0 and T1 RDY -> thr_run stays 0; release -> 4'b0010 next cycle; thr_stop on RUN thread -> thr_halt bit set, thr_run=0.
- Macro on: T3 WAIT, spec_cmpl[3], no RDY -> T3 RUN two cycles later; macro off same stimulus -> thr_run=0, all_idle=1.

Source files
------------

// File: rtl/sparc_ifu_thrsched_pkg.sv
// Shared types for the IFU thread scheduler: state codes, thread count,
// round-robin pointer width and the rotating-priority search helper.
package sparc_ifu_thrsched_pkg;

   localparam int NTHR  = 4;
   localparam int PTR_W = 2;

   typedef enum logic [2:0] {
      ST_HALT = 3'd0,
      ST_RDY  = 3'd1,
      ST_RUN  = 3'd2,
      ST_WAIT = 3'd3,
      ST_SPEC = 3'd4
   } thr_st_e;

   typedef struct packed {
      logic             hit;
      logic [PTR_W-1:0] idx;
   } pick_t;

   // First requester after ptr, wrapping; ptr itself is checked last.
   function automatic pick_t rr_pick(input logic [NTHR-1:0]  req,
                                     input logic [PTR_W-1:0] ptr);
      pick_t            p;
      logic [PTR_W-1:0] j;
      p = '0;
      for (int k = 1; k <= NTHR; k++) begin
         j = ptr + PTR_W'(k);
         if (!p.hit && req[j]) begin
            p.hit = 1'b1;
            p.idx = j;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/sparc_ifu_thrsched_thrfsm.sv
// Per-thread scheduling state machine (HALT/RDY/RUN/WAIT/SPEC).
// SPEC handling is built only with SPARC_IFU_THRSCHED_SPEC_EN.
module sparc_ifu_thrfsm
   import sparc_ifu_thrsched_pkg::*;
(
   input  logic    clk,
   input  logic    arst_l,
   input  logic    stop,
   input  logic    start,
   input  logic    cmpl,
   input  logic    spec_cmpl,
   input  logic    spec_fail,
   input  logic    sw,
   input  logic    yl,
   input  logic    sel,
   output thr_st_e st,
   output thr_st_e nxt
);

`ifndef SPARC_IFU_THRSCHED_SPEC_EN
   logic spec_unused;
   assign spec_unused = spec_cmpl ^ spec_fail;
`endif

   always_comb begin
      nxt = st;
      if (stop) begin
         nxt = ST_HALT;
      end else begin
         case (st)
            ST_HALT: if (start) nxt = ST_RDY;
            ST_RDY:  if (sel)   nxt = ST_RUN;
            ST_RUN: begin
               // a completion racing the switch skips WAIT entirely
               if (sw)      nxt = cmpl ? ST_RDY : ST_WAIT;
               else if (yl) nxt = ST_RDY;
            end
            ST_WAIT: begin
               if (cmpl) nxt = ST_RDY;
`ifdef SPARC_IFU_THRSCHED_SPEC_EN
               else if (spec_cmpl) nxt = ST_SPEC;
`endif
            end
`ifdef SPARC_IFU_THRSCHED_SPEC_EN
            ST_SPEC: begin
               if (cmpl)           nxt = ST_RDY;
               else if (spec_fail) nxt = ST_WAIT;
               else if (sel)       nxt = ST_RUN;
            end
`endif
            default: nxt = ST_HALT;
         endcase
      end
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) st <= ST_HALT;
      else         st <= nxt;
   end

endmodule

// File: rtl/sparc_ifu_thrsched.sv
// IFU thread scheduler: four thread FSMs, round-robin picker, registered
// one-hot run vector. SPEC selection enabled by SPARC_IFU_THRSCHED_SPEC_EN.
module sparc_ifu_thrsched #(
   parameter int NTHR = 4
) (
   input  logic            clk,
   input  logic            arst_l,
   input  logic [NTHR-1:0] thr_start,
   input  logic [NTHR-1:0] thr_stop,
   input  logic [NTHR-1:0] completion,
   input  logic [NTHR-1:0] spec_cmpl,
   input  logic [NTHR-1:0] spec_fail,
   input  logic            switch_s,
   input  logic            yield_s,
   input  logic            stall_s,
   output logic [NTHR-1:0] thr_run,
   output logic [NTHR-1:0] thr_rdy,
   output logic [NTHR-1:0] thr_wait,
   output logic [NTHR-1:0] thr_halt,
   output logic            all_idle
);
   import sparc_ifu_thrsched_pkg::*;

   thr_st_e          st  [NTHR];
   thr_st_e          nxt [NTHR];
   logic [NTHR-1:0]  is_rdy, is_spec, is_wait, is_halt, run_nxt, sel;
   logic [PTR_W-1:0] rr_ptr;
   logic             can_sel;
   pick_t            p_win;

   always_comb begin
      for (int i = 0; i < NTHR; i++) begin
         is_rdy[i]  = (st[i] == ST_RDY);
         is_spec[i] = (st[i] == ST_SPEC);
         is_wait[i] = (st[i] == ST_WAIT);
         is_halt[i] = (st[i] == ST_HALT);
         run_nxt[i] = (nxt[i] == ST_RUN);
      end
   end

   // a stop alone does not open the slot this cycle; it reselects next cycle
   assign can_sel = !stall_s && (~|thr_run || switch_s || yield_s);

   always_comb begin
`ifdef SPARC_IFU_THRSCHED_SPEC_EN
      pick_t p_rdy, p_spec;
      p_rdy  = rr_pick(is_rdy, rr_ptr);
      p_spec = rr_pick(is_spec, rr_ptr);
      p_win  = p_rdy.hit ? p_rdy : p_spec;
`else
      p_win  = rr_pick(is_rdy, rr_ptr);
`endif
      sel = '0;
      if (can_sel && p_win.hit) sel[p_win.idx] = 1'b1;
   end

   for (genvar g = 0; g < NTHR; g++) begin : g_thr
      sparc_ifu_thrfsm u_fsm (
         .clk       (clk),
         .arst_l    (arst_l),
         .stop      (thr_stop[g]),
         .start     (thr_start[g]),
         .cmpl      (completion[g]),
         .spec_cmpl (spec_cmpl[g]),
         .spec_fail (spec_fail[g]),
         .sw        (switch_s & thr_run[g]),
         .yl        (yield_s & thr_run[g]),
         .sel       (sel[g]),
         .st        (st[g]),
         .nxt       (nxt[g])
      );
   end

   always_ff @(posedge clk or negedge arst_l) begin
      if (!arst_l) begin
         rr_ptr  <= PTR_W'(3);
         thr_run <= '0;
      end else begin
         if (can_sel && p_win.hit) rr_ptr <= p_win.idx;
         thr_run <= run_nxt;
      end
   end

   assign thr_rdy  = is_rdy;
   assign thr_wait = is_wait | is_spec;
   assign thr_halt = is_halt;
   assign all_idle = ~|(thr_run | is_rdy | is_spec);

endmodule
